// File: rtl/mod_arith_pkg.sv
// Shared modular-arithmetic definitions: opcode encodings and standard moduli.
package mod_arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_NEG  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  localparam int unsigned KYBER_Q     = 3329;
  localparam int unsigned KYBER_W     = 12;
  localparam int unsigned DILITHIUM_Q = 8380417;
  localparam int unsigned DILITHIUM_W = 23;

  // Only add and sub consume operand B; its range error is ignored otherwise.
  function automatic logic op_uses_b(op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/mod_addsub_lane.sv
// One lane of the modular add/sub pipeline: raw result in stage 1,
// single conditional correction by Q in stage 2.
module mod_addsub_lane
  import mod_arith_pkg::*;
#(
  parameter int unsigned Q = KYBER_Q,
  parameter int unsigned W = KYBER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  op_e          i_op1,
  input  op_e          i_op2,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_c,
  output logic         o_err
);

  localparam logic signed [W+1:0] QS = (W+2)'(Q);
  localparam logic        [W-1:0] QW = W'(Q);

  logic signed [W+1:0] w_a;
  logic signed [W+1:0] w_b;
  logic signed [W+1:0] w_raw;
  logic                w_err;
  logic        [W-1:0] w_fix;

  logic signed [W+1:0] r_raw;
  logic                r_err;

  assign w_a = signed'({2'b00, i_a});
  assign w_b = signed'({2'b00, i_b});

  always_comb begin
    w_raw = w_a;
    unique case (i_op1)
      OP_ADD:  w_raw = w_a + w_b;
      OP_SUB:  w_raw = w_a - w_b;
      OP_NEG:  w_raw = QS - w_a;
      OP_PASS: w_raw = w_a;
      default: w_raw = w_a;
    endcase
  end

  assign w_err = (i_a >= QW) || (op_uses_b(i_op1) && (i_b >= QW));

  // neg of zero yields exactly Q in stage 1; any A > Q yields a negative raw value
  always_comb begin
    w_fix = W'(r_raw);
    unique case (i_op2)
      OP_ADD:  w_fix = (r_raw >= QS) ? W'(r_raw - QS) : W'(r_raw);
      OP_SUB:  w_fix = (r_raw < 0)   ? W'(r_raw + QS) : W'(r_raw);
      OP_NEG:  w_fix = (r_raw == QS) ? '0 : W'(r_raw);
      OP_PASS: w_fix = W'(r_raw);
      default: w_fix = W'(r_raw);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_raw <= '0;
      r_err <= 1'b0;
      o_c   <= '0;
      o_err <= 1'b0;
    end else if (i_en) begin
      r_raw <= w_raw;
      r_err <= w_err;
      o_c   <= w_fix;
      o_err <= r_err;
    end
  end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Multi-lane two-stage modular add/sub/neg/pass unit with valid/ready stream
// handshake; a single global enable stalls both stages together.
module mod_addsub_pipe
  import mod_arith_pkg::*;
#(
  parameter int unsigned Q     = KYBER_Q,
  parameter int unsigned W     = KYBER_W,
  parameter int unsigned LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [LANES*W-1:0] in_a,
  input  logic [LANES*W-1:0] in_b,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_c,
  output logic [LANES-1:0]   out_err,
  output logic               out_last
);

  logic w_en;
  op_e  w_op_in;

  logic r_v1;
  logic r_v2;
  op_e  r_op1;
  logic r_last1;
  logic r_last2;

  assign w_en      = !r_v2 || out_ready;
  assign in_ready  = w_en;
  assign w_op_in   = op_e'(in_op);
  assign out_valid = r_v2;
  assign out_last  = r_last2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_op1   <= OP_ADD;
      r_last1 <= 1'b0;
      r_last2 <= 1'b0;
    end else if (w_en) begin
      r_v1    <= in_valid;
      r_v2    <= r_v1;
      r_op1   <= w_op_in;
      r_last1 <= in_last;
      r_last2 <= r_last1;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mod_addsub_lane #(
      .Q (Q),
      .W (W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_en),
      .i_op1 (w_op_in),
      .i_op2 (r_op1),
      .i_a   (in_a[g*W +: W]),
      .i_b   (in_b[g*W +: W]),
      .o_c   (out_c[g*W +: W]),
      .o_err (out_err[g])
    );
  end

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Directed bench: Kyber 4-lane instance plus a single-lane Dilithium instance.
module tb_mod_addsub_pipe;

  localparam int KQ = 3329;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic [1:0]  in_op;
  logic [47:0] in_a, in_b, out_c;
  logic [3:0]  out_err;

  logic        d_in_valid, d_in_ready, d_in_last, d_out_valid, d_out_ready, d_out_last;
  logic [1:0]  d_in_op;
  logic [22:0] d_in_a, d_in_b, d_out_c;
  logic [0:0]  d_out_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mod_addsub_pipe #(.Q(3329), .W(12), .LANES(4)) dut_k (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_err(out_err), .out_last(out_last)
  );

  mod_addsub_pipe #(.Q(8380417), .W(23), .LANES(1)) dut_d (
    .clk(clk), .rst(rst),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_op(d_in_op),
    .in_a(d_in_a), .in_b(d_in_b), .in_last(d_in_last),
    .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_c(d_out_c), .out_err(d_out_err), .out_last(d_out_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {12'(l3), 12'(l2), 12'(l1), 12'(l0)};
  endfunction

  // One isolated beat: checks acceptance, 2-cycle latency, data and trailing bubble.
  task automatic run_k(input string tag, input logic [1:0] op, input logic [47:0] a,
                       input logic [47:0] b, input logic last,
                       input logic [47:0] ec, input logic [3:0] ee);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_last = last; out_ready = 1'b1;
    #1;
    chk({tag, "/in_ready"}, 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
    chk({tag, "/valid_c1"}, 64'(out_valid), 64'(0));
    tick();
    chk({tag, "/valid_c2"}, 64'(out_valid), 64'(1));
    chk({tag, "/c"},        64'(out_c),     64'(ec));
    chk({tag, "/err"},      64'(out_err),   64'(ee));
    chk({tag, "/last"},     64'(out_last),  64'(last));
    tick();
    chk({tag, "/bubble"},   64'(out_valid), 64'(0));
  endtask

  task automatic run_d(input string tag, input logic [1:0] op, input logic [22:0] a,
                       input logic [22:0] b, input logic [22:0] ec);
    d_in_valid = 1'b1; d_in_op = op; d_in_a = a; d_in_b = b; d_in_last = 1'b1;
    tick();
    d_in_valid = 1'b0; d_in_last = 1'b0;
    chk({tag, "/valid_c1"}, 64'(d_out_valid), 64'(0));
    tick();
    chk({tag, "/valid_c2"}, 64'(d_out_valid), 64'(1));
    chk({tag, "/c"},        64'(d_out_c),     64'(ec));
    chk({tag, "/err"},      64'(d_out_err),   64'(0));
    chk({tag, "/last"},     64'(d_out_last),  64'(1));
    tick();
  endtask

  initial begin
    int bi;
    int got;
    logic [48:0] expq[$];
    logic [48:0] exp_front;
    int av;

    rst = 1'b1;
    in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
    d_in_valid = 1'b0; d_in_op = 2'b00; d_in_a = '0; d_in_b = '0; d_in_last = 1'b0;
    d_out_ready = 1'b1;
    tick(); tick();
    chk("reset/out_valid", 64'(out_valid), 64'(0));
    chk("reset/in_ready",  64'(in_ready),  64'(1));
    chk("reset/out_c",     64'(out_c),     64'(0));
    chk("reset/out_err",   64'(out_err),   64'(0));
    chk("reset/out_last",  64'(out_last),  64'(0));
    chk("reset/d_valid",   64'(d_out_valid), 64'(0));
    rst = 1'b0;
    tick();

    run_k("add", 2'b00, pk(3000, 1664, 0, 3328), pk(500, 1664, 0, 1), 1'b1,
          pk(171, 3328, 0, 0), 4'b0000);
    run_k("sub", 2'b01, pk(5, 7, 0, 3328), pk(10, 7, 3328, 0), 1'b0,
          pk(3324, 0, 1, 3328), 4'b0000);
    run_k("neg", 2'b10, pk(0, 1, 3328, 5), pk(4000, 4000, 4000, 4000), 1'b1,
          pk(0, 3328, 1, 3324), 4'b0000);
    run_k("pass", 2'b11, pk(3328, 0, 17, 100), pk(4095, 4095, 4095, 4095), 1'b0,
          pk(3328, 0, 17, 100), 4'b0000);
    run_k("range", 2'b00, pk(1, 10, 3329, 3328), pk(2, 20, 0, 3328), 1'b0,
          pk(3, 30, 0, 3327), 4'b0100);

    run_d("dil_sub", 2'b01, 23'd0, 23'd1, 23'd8380416);
    run_d("dil_add", 2'b00, 23'd8380416, 23'd8380416, 23'd8380415);

    // 8 back-to-back beats, downstream stalls in cycles 3..5
    bi = 0; got = 0;
    for (int cyc = 0; cyc < 30 && got < 8; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      if (bi < 8) begin
        in_valid = 1'b1; in_op = 2'b00; in_last = (bi % 4 == 3);
        in_a = pk((bi*400) % KQ, (bi*400 + 700) % KQ, (bi*400 + 1400) % KQ,
                  (bi*400 + 2100) % KQ);
        in_b = pk(3000, 3000, 3000, 3000);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("stream/in_ready", 64'(in_ready), 64'((cyc >= 3 && cyc <= 5) ? 0 : 1));
      if (cyc >= 3 && cyc <= 5) chk("stream/stall_valid", 64'(out_valid), 64'(1));
      if (out_valid) begin
        exp_front = (expq.size() > 0) ? expq[0] : '1;
        chk("stream/c",    64'(out_c),    64'(exp_front[47:0]));
        chk("stream/last", 64'(out_last), 64'(exp_front[48]));
        if (out_ready) begin
          if (expq.size() > 0) void'(expq.pop_front());
          got++;
        end
      end
      if (in_valid && in_ready) begin
        exp_front[48] = (bi % 4 == 3);
        for (int l = 0; l < 4; l++) begin
          av = (bi*400 + l*700) % KQ;
          exp_front[l*12 +: 12] = 12'((av + 3000) % KQ);
        end
        expq.push_back(exp_front);
        bi++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream/count",   64'(got),         64'(8));
    chk("stream/pending", 64'(expq.size()), 64'(0));
    tick();
    chk("stream/drained", 64'(out_valid), 64'(0));

    // reset with two beats in flight; rst overrides a simultaneous in_valid
    in_valid = 1'b1; in_op = 2'b11; in_a = pk(1, 2, 3, 4); in_last = 1'b1;
    tick();
    in_a = pk(5, 6, 7, 8);
    tick();
    chk("rst/pre_valid", 64'(out_valid), 64'(1));
    rst = 1'b1;
    tick();
    chk("rst/valid_r0", 64'(out_valid), 64'(0));
    chk("rst/c_r0",     64'(out_c),     64'(0));
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("rst/valid_r1", 64'(out_valid), 64'(0));
    tick();
    chk("rst/valid_r2", 64'(out_valid), 64'(0));
    run_k("post_rst", 2'b01, pk(100, 0, 3328, 50), pk(1, 1, 3328, 60), 1'b1,
          pk(99, 3328, 0, 3319), 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
